universal_shift_register: RTL and testbench

- Parametrised successor to the 4-bit parallel-load register: WIDTH-bit register with hold, parallel load, logical and arithmetic shifts, rotates and synchronous clear.
- Adds serial in/out and an automatic multi-step shift command (Start/Amt) with Busy/Done handshake.
- Used as a datapath operand register and shifter in the lab CPU datapath.

---
 rtl/universal_shift_register.sv | 99 +++++++++
 tb/tb_universal_shift_register.sv | 107 ++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// universal_shift_register: WIDTH-bit register with load/shift/rotate/clear and multi-step Start/Amt command
// Ports: CLK clock; CLRn async active-low reset; Mode op select; Start/Amt multi-step command;
//        D load data; SinL/SinR serial inputs; Q contents; SoutL/SoutR last bits out; Busy/Done handshake
module universal_shift_register #(
    parameter  int WIDTH = 4,
    localparam int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             CLRn,
    input  logic [2:0]       Mode,
    input  logic             Start,
    input  logic [AMT_W-1:0] Amt,
    input  logic [WIDTH-1:0] D,
    input  logic             SinL,
    input  logic             SinR,
    output logic [WIDTH-1:0] Q,
    output logic             SoutL,
    output logic             SoutR,
    output logic             Busy,
    output logic             Done
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           r_state;
    logic [2:0]       r_cmd;
    logic [AMT_W-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic             r_soutl, r_soutr, r_busy, r_done;
    logic [2:0]       w_op;
    logic [WIDTH-1:0] w_q;
    logic             w_sl, w_sr, w_shift;
    logic [AMT_W-1:0] w_neff;
    assign Q     = r_q;
    assign SoutL = r_soutl;
    assign SoutR = r_soutr;
    assign Busy  = r_busy;
    assign Done  = r_done;
    always_comb begin
        w_op    = (r_state == RUN) ? r_cmd : Mode;
        w_shift = !(Mode inside {3'b000, 3'b001, 3'b111});
        w_neff  = (Amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : Amt;
        w_q     = r_q;
        w_sl    = r_soutl;
        w_sr    = r_soutr;
        case (w_op)
            3'b001: w_q = D;
            3'b010: begin w_q = {r_q[WIDTH-2:0], SinR};       w_sl = r_q[WIDTH-1]; end
            3'b011: begin w_q = {SinL, r_q[WIDTH-1:1]};       w_sr = r_q[0];       end
            3'b100: begin w_q = {r_q[WIDTH-2:0], r_q[WIDTH-1]}; w_sl = r_q[WIDTH-1]; end
            3'b101: begin w_q = {r_q[0], r_q[WIDTH-1:1]};     w_sr = r_q[0];       end
            3'b110: begin w_q = {r_q[WIDTH-1], r_q[WIDTH-1:1]}; w_sr = r_q[0];     end
            3'b111: w_q = '0;
            default: ;
        endcase
    end
    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            r_state <= IDLE;
            r_cmd   <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_soutl <= 1'b0;
            r_soutr <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == RUN) begin
                r_q     <= w_q;
                r_soutl <= w_sl;
                r_soutr <= w_sr;
                r_rem   <= r_rem - AMT_W'(1);
                if (r_rem == AMT_W'(1)) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
            end else if (!Start || !w_shift || w_neff != '0) begin
                // plain op, non-shift Start, or first step of a shift Start
                r_q     <= w_q;
                r_soutl <= w_sl;
                r_soutr <= w_sr;
                if (Start) begin
                    r_cmd <= Mode;
                    if (w_shift && w_neff > AMT_W'(1)) begin
                        r_rem   <= w_neff - AMT_W'(1);
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
            end else begin
                // shift Start with zero steps: Q untouched, completion only
                r_cmd  <= Mode;
                r_done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_universal_shift_register.sv
// tb_universal_shift_register: directed self-checking bench for universal_shift_register (WIDTH=4)
// Ports: none; drives CLK/CLRn and all command inputs of the DUT
module tb_universal_shift_register;
    logic       CLK = 1'b0;
    logic       CLRn, Start, SinL, SinR, SoutL, SoutR, Busy, Done;
    logic [2:0] Mode, Amt;
    logic [3:0] D, Q;
    int checks = 0;
    int failures = 0;

    universal_shift_register #(.WIDTH(4)) dut (
        .CLK(CLK), .CLRn(CLRn), .Mode(Mode), .Start(Start), .Amt(Amt), .D(D),
        .SinL(SinL), .SinR(SinR), .Q(Q), .SoutL(SoutL), .SoutR(SoutR), .Busy(Busy), .Done(Done)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] q, input logic b, input logic d);
        chk({tag, "_q"}, 32'(Q), 32'(q));
        chk({tag, "_busy"}, 32'(Busy), 32'(b));
        chk({tag, "_done"}, 32'(Done), 32'(d));
    endtask

    initial begin
        CLRn = 1'b0; Start = 1'b0; Mode = 3'b000; Amt = 3'd0; D = 4'h0; SinL = 1'b0; SinR = 1'b0;
        step(); step();
        chk_all("reset", 4'b0000, 1'b0, 1'b0);
        chk("reset_soutl", 32'(SoutL), 32'd0);
        chk("reset_soutr", 32'(SoutR), 32'd0);
        CLRn = 1'b1; Mode = 3'b001; D = 4'b1011;
        step(); chk_all("load", 4'b1011, 1'b0, 1'b0);
        Mode = 3'b000; D = 4'b0000;
        step(); step(); step(); chk_all("hold3", 4'b1011, 1'b0, 1'b0);
        Mode = 3'b010; SinR = 1'b1;
        step(); chk_all("shl", 4'b0111, 1'b0, 1'b0);
        chk("shl_soutl", 32'(SoutL), 32'd1);
        Mode = 3'b011; SinL = 1'b0; SinR = 1'b0;
        step(); chk_all("shr", 4'b0011, 1'b0, 1'b0);
        chk("shr_soutr", 32'(SoutR), 32'd1);
        Mode = 3'b001; D = 4'b1000;
        step(); chk("load1000_soutr_held", 32'(SoutR), 32'd1);
        Mode = 3'b110;
        step(); chk_all("ashr", 4'b1100, 1'b0, 1'b0);
        chk("ashr_soutr", 32'(SoutR), 32'd0);
        Mode = 3'b001; D = 4'b0001;
        step();
        Mode = 3'b100; Start = 1'b1; Amt = 3'd3;
        step(); chk_all("rotl3_s1", 4'b0010, 1'b1, 1'b0);
        Start = 1'b0; Mode = 3'b111; D = 4'b1111; Amt = 3'd0;
        step(); chk_all("rotl3_s2", 4'b0100, 1'b1, 1'b0);
        step(); chk_all("rotl3_s3", 4'b1000, 1'b0, 1'b1);
        chk("rotl3_soutl", 32'(SoutL), 32'd0);
        Mode = 3'b000;
        step(); chk_all("rotl3_after", 4'b1000, 1'b0, 1'b0);
        Start = 1'b1; Mode = 3'b010; Amt = 3'd0; SinR = 1'b1;
        step(); chk_all("amt0", 4'b1000, 1'b0, 1'b1);
        Start = 1'b0; Mode = 3'b000; SinR = 1'b0;
        step(); chk_all("amt0_after", 4'b1000, 1'b0, 1'b0);
        Mode = 3'b001; D = 4'b1001;
        step();
        Start = 1'b1; Mode = 3'b101; Amt = 3'd7;
        step(); chk_all("rotr7_s1", 4'b1100, 1'b1, 1'b0);
        Start = 1'b0; Mode = 3'b000; Amt = 3'd0;
        step(); chk_all("rotr7_s2", 4'b0110, 1'b1, 1'b0);
        step(); chk_all("rotr7_s3", 4'b0011, 1'b1, 1'b0);
        step(); chk_all("rotr7_s4", 4'b1001, 1'b0, 1'b1);
        chk("rotr7_soutr", 32'(SoutR), 32'd1);
        step(); chk_all("rotr7_after", 4'b1001, 1'b0, 1'b0);
        Start = 1'b1; Mode = 3'b001; D = 4'b0110; Amt = 3'd2;
        step(); chk_all("start_load", 4'b0110, 1'b0, 1'b1);
        Start = 1'b0; Mode = 3'b000; Amt = 3'd0;
        step(); chk_all("start_load_after", 4'b0110, 1'b0, 1'b0);
        Mode = 3'b001; D = 4'b1111;
        step();
        Start = 1'b1; Mode = 3'b010; Amt = 3'd4; SinR = 1'b0;
        step(); chk_all("rst_mid_s1", 4'b1110, 1'b1, 1'b0);
        Start = 1'b0; Mode = 3'b000; Amt = 3'd0;
        step(); chk_all("rst_mid_s2", 4'b1100, 1'b1, 1'b0);
        #2 CLRn = 1'b0;
        #1 chk_all("rst_mid_async", 4'b0000, 1'b0, 1'b0);
        step(); CLRn = 1'b1;
        step(); chk_all("rst_rel1", 4'b0000, 1'b0, 1'b0);
        step(); chk_all("rst_rel2", 4'b0000, 1'b0, 1'b0);
        Start = 1'b1; Mode = 3'b000; Amt = 3'd1;
        step(); chk_all("b2b_first", 4'b0000, 1'b0, 1'b1);
        Mode = 3'b011; Amt = 3'd2; SinL = 1'b1;
        step(); chk_all("b2b_s1", 4'b1000, 1'b1, 1'b0);
        Start = 1'b0; Mode = 3'b000; Amt = 3'd0;
        step(); chk_all("b2b_s2", 4'b1100, 1'b0, 1'b1);
        step(); chk_all("b2b_after", 4'b1100, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
